frame_logic_reducer: RTL and testbench



---
 rtl/frame_logic_reducer.sv | 180 ++++++++++++++++++
 tb/tb_frame_logic_reducer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_logic_reducer.sv
// Frame logic reducer: folds every bit of a WIDTH-bit word frame through
// AND / OR / XOR / MAJORITY and returns the result, an all-bits-equal flag,
// a saturating ones count and an overflow flag via a one-entry output register.
//
// state | meaning
// IDLE  | waiting for the first word of a frame
// ACCUM | accumulating the remaining words of a frame
// DONE  | one cycle: resolve the selected op and load the output register
// HOLD  | result presented, waiting for downstream to accept it
module frame_logic_reducer #(
  parameter int WIDTH     = 6,
  parameter int MAX_WORDS = 16,
  parameter int CW        = $clog2(WIDTH*MAX_WORDS+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             in_last,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             z1,
  output logic             z2,
  output logic [CW-1:0]    ones,
  output logic             ovf
);

  // words_q only needs to reach MAX_WORDS; anything beyond that is overflow
  localparam int WW = $clog2(MAX_WORDS+1);
  localparam logic [CW-1:0] SAT     = '1;
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [WW-1:0] MAXW_C  = WW'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE, HOLD} state_t;

  state_t          state_q, state_d;
  logic            rdy_q;
  logic [1:0]      op_q, op_d;
  logic            and_q, and_d, or_q, or_d, xor_q, xor_d;
  logic [CW-1:0]   ones_q, ones_d, bits_q, bits_d;
  logic [WW-1:0]   words_q, words_d;
  logic            ovf_q, ovf_d;
  logic            out_valid_q, out_valid_d;
  logic            z1_q, z1_d, z2_q, z2_d, ovf_out_q, ovf_out_d;
  logic [CW-1:0]   ones_out_q, ones_out_d;

  logic [CW-1:0]   pop;
  logic [CW:0]     ones_sum, bits_sum;
  logic [CW-1:0]   ones_acc, bits_acc;
  logic            maj;
  logic            xfer_in;

  // Popcount of the incoming word, zero-extended to the counter width
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + CW'(din[i]);
  end

  // Saturating accumulation and majority compare (ties resolve to 0)
  assign ones_sum = {1'b0, ones_q} + {1'b0, pop};
  assign bits_sum = {1'b0, bits_q} + {1'b0, WIDTH_C};
  assign ones_acc = ones_sum[CW] ? SAT : ones_sum[CW-1:0];
  assign bits_acc = bits_sum[CW] ? SAT : bits_sum[CW-1:0];
  assign maj      = {ones_q, 1'b0} > {1'b0, bits_q};

  // rdy_q keeps in_ready low until the first edge after reset release
  assign in_ready = rdy_q && ((state_q == IDLE) || (state_q == ACCUM));
  assign xfer_in  = in_valid && in_ready;

  // Next-state, accumulator and output-register update
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    and_d       = and_q;
    or_d        = or_q;
    xor_d       = xor_q;
    ones_d      = ones_q;
    bits_d      = bits_q;
    words_d     = words_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    z1_d        = z1_q;
    z2_d        = z2_q;
    ones_out_d  = ones_out_q;
    ovf_out_d   = ovf_out_q;
    case (state_q)
      IDLE: begin
        if (xfer_in) begin
          op_d    = op;
          and_d   = &din;
          or_d    = |din;
          xor_d   = ^din;
          ones_d  = pop;
          bits_d  = WIDTH_C;
          words_d = WW'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer_in) begin
          and_d  = and_q & (&din);
          or_d   = or_q | (|din);
          xor_d  = xor_q ^ (^din);
          ones_d = ones_acc;
          bits_d = bits_acc;
          if (words_q >= MAXW_C) ovf_d = 1'b1;
          else                   words_d = words_q + WW'(1);
          if (in_last) state_d = DONE;
        end
      end
      DONE: begin
        case (op_q)
          2'b00:   z1_d = and_q;
          2'b01:   z1_d = or_q;
          2'b10:   z1_d = xor_q;
          default: z1_d = maj;
        endcase
        z2_d        = and_q | ~or_q;
        ones_out_d  = ones_q;
        ovf_out_d   = ovf_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      op_q        <= 2'b00;
      and_q       <= 1'b0;
      or_q        <= 1'b0;
      xor_q       <= 1'b0;
      ones_q      <= '0;
      bits_q      <= '0;
      words_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      z1_q        <= 1'b0;
      z2_q        <= 1'b0;
      ones_out_q  <= '0;
      ovf_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      op_q        <= op_d;
      and_q       <= and_d;
      or_q        <= or_d;
      xor_q       <= xor_d;
      ones_q      <= ones_d;
      bits_q      <= bits_d;
      words_q     <= words_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      z1_q        <= z1_d;
      z2_q        <= z2_d;
      ones_out_q  <= ones_out_d;
      ovf_out_q   <= ovf_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign z1        = z1_q;
  assign z2        = z2_q;
  assign ones      = ones_out_q;
  assign ovf       = ovf_out_q;

endmodule

// File: tb/tb_frame_logic_reducer.sv
// Bench for frame_logic_reducer: a driver pushes the expected result of each
// frame (from a bit-counting reference model) and a monitor checks every
// presented result, its latency and its stability under backpressure.
module tb_frame_logic_reducer;

  localparam int WIDTH = 6;
  localparam int MAXW  = 16;
  localparam int CW    = 7;
  localparam int SATV  = 127;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] din = '0;
  logic             in_last = 1'b0;
  logic [1:0]       op = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             z1, z2, ovf;
  logic [CW-1:0]    ones;

  frame_logic_reducer #(.WIDTH(WIDTH), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .in_last(in_last), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .z1(z1), .z2(z2), .ones(ones), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int z1; int z2; int ones; int ovf; int vcyc;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int or_mode = 0;  // 0: out_ready=1, 1: random, 2: out_ready=0

  logic [WIDTH-1:0] w[64];
  logic [1:0]       opv[64];

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model: everything follows from the frame's true ones/bit counts
  task automatic push_expect(input int n, input int vcyc);
    exp_t e;
    int ones_t = 0;
    int bits_t = n * WIDTH;
    int os, bs;
    for (int i = 0; i < n; i++) ones_t += $countones(w[i]);
    os = (ones_t > SATV) ? SATV : ones_t;
    bs = (bits_t > SATV) ? SATV : bits_t;
    case (opv[0])
      2'd0:    e.z1 = (ones_t == bits_t) ? 1 : 0;
      2'd1:    e.z1 = (ones_t > 0) ? 1 : 0;
      2'd2:    e.z1 = ones_t % 2;
      default: e.z1 = (2 * os > bs) ? 1 : 0;
    endcase
    e.z2   = (ones_t == 0 || ones_t == bits_t) ? 1 : 0;
    e.ones = os;
    e.ovf  = (n > MAXW) ? 1 : 0;
    e.vcyc = vcyc;
    sbq.push_back(e);
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      @(negedge clk);
      in_valid = 1'b1;
      din      = w[i];
      op       = opv[i];
      in_last  = (i == n - 1);
      while (!in_ready && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (g >= 200) begin
        chk("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      if (i == n - 1) push_expect(n, cyc + 2);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((sbq.size() != 0 || out_valid) && g < 600) begin
      @(negedge clk);
      g++;
    end
    if (g >= 600) chk("drain_timeout", 0, 1);
    @(negedge clk);
    #1;
  endtask

  // Monitor: drives out_ready, checks latency, hold stability and results
  initial begin
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? 1'($urandom) : 1'b0;
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid) begin
          if (sbq.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            if (!prev_v) chk("latency_cycle", cyc, sbq[0].vcyc);
            if (!out_ready) begin
              chk("hold_z1", int'(z1), sbq[0].z1);
              chk("hold_ones", int'(ones), sbq[0].ones);
            end else begin
              exp_t e;
              e = sbq.pop_front();
              chk("z1", int'(z1), e.z1);
              chk("z2", int'(z2), e.z2);
              chk("ones", int'(ones), e.ones);
              chk("ovf", int'(ovf), e.ovf);
            end
          end
        end
        prev_v = out_valid;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_z1", int'(z1), 0);
    chk("rst_z2", int'(z2), 0);
    chk("rst_ones", int'(ones), 0);
    chk("rst_ovf", int'(ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("rel_in_ready_after_edge", int'(in_ready), 1);

    // Single-word frames
    w[0] = 6'b000000; opv[0] = 2'b00; send_frame(1);
    w[0] = 6'b111111; opv[0] = 2'b00; send_frame(1);
    w[0] = 6'b010101; opv[0] = 2'b10; send_frame(1);
    w[0] = 6'b101010; opv[0] = 2'b01; send_frame(1);
    drain();

    // Reset asserted mid-cycle during ACCUM discards the frame
    @(negedge clk);
    in_valid = 1'b1; din = 6'b111111; op = 2'b01; in_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_z1", int'(z1), 0);
    chk("midrst_ones", int'(ones), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_rel_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("midrst_rel_in_ready_edge", int'(in_ready), 1);
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("midrst_no_out_valid", int'(out_valid), 0);
    end

    // Majority tie, then majority win
    w[0] = 6'b111000; w[1] = 6'b000111; opv[0] = 2'b11; opv[1] = 2'b11;
    send_frame(2);
    w[0] = 6'b111000; w[1] = 6'b001111;
    send_frame(2);

    // Overflow: 20 words of ones, op OR
    for (int i = 0; i < 20; i++) begin w[i] = 6'b111111; opv[i] = 2'b01; end
    send_frame(20);

    // op change mid-frame is ignored
    w[0] = 6'b111111; opv[0] = 2'b00; w[1] = 6'b011111; opv[1] = 2'b01;
    send_frame(2);
    drain();

    // Backpressure: hold out_ready low, then release
    or_mode = 2;
    w[0] = 6'b110011; opv[0] = 2'b10;
    send_frame(1);
    begin
      int g = 0;
      while (!out_valid && g < 50) begin
        @(negedge clk);
        #1;
        g++;
      end
      chk("bp_out_valid_seen", int'(out_valid), 1);
    end
    repeat (5) begin
      chk("bp_in_ready_low", int'(in_ready), 0);
      chk("bp_out_valid_high", int'(out_valid), 1);
      @(negedge clk);
      #1;
    end
    or_mode = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("bp_out_valid_drop", int'(out_valid), 0);
    chk("bp_in_ready_back", int'(in_ready), 1);
    w[0] = 6'b000001; opv[0] = 2'b01;
    send_frame(1);
    drain();

    // Randomized frames with random backpressure
    or_mode = 1;
    for (int f = 0; f < 60; f++) begin
      int n;
      logic all1;
      all1 = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        n = $urandom_range(15, 24);
        all1 = ($urandom_range(0, 1) == 1);
      end else begin
        n = $urandom_range(1, 4);
      end
      for (int i = 0; i < n; i++) begin
        w[i]   = all1 ? 6'b111111 : 6'($urandom);
        opv[i] = 2'($urandom);
      end
      send_frame(n);
    end
    drain();
    or_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
